// File: rtl/icache_pkg.sv
// icache_pkg: shared request-source type, default geometry and line helper for the I-cache L2 path
package icache_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_OFF_DEF = 6;
  typedef enum logic {SRC_DEMAND, SRC_PREF} req_src_e;
  function automatic logic [ADDR_W_DEF-LINE_OFF_DEF-1:0] line_of(input logic [ADDR_W_DEF-1:0] addr);
    return addr[ADDR_W_DEF-1:LINE_OFF_DEF];
  endfunction
endpackage

// File: rtl/icache_req_slot.sv
// icache_req_slot: one-entry valid/ready register stage holding {addr, src}
module icache_req_slot #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic              in_src_i,
  output logic              load_en_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_src_o,
  input  logic              out_ready_i
);
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              src_q;
  assign load_en_o   = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_src_o   = src_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      src_q   <= 1'b0;
    end else if (load_en_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        addr_q <= in_addr_i;
        src_q  <= in_src_i;
      end
    end
  end
endmodule

// File: rtl/icache_mem_arb.sv
// icache_mem_arb: shares the L2 request port between MSHR demand misses and prefetches,
// with demand priority, a prefetch starvation guard and duplicate-prefetch dropping.
module icache_mem_arb
  import icache_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int LINE_OFF      = LINE_OFF_DEF,
  parameter int PF_STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mshr_req_valid,
  input  logic [ADDR_W-1:0] mshr_req_addr,
  output logic              mshr_req_ready,
  input  logic              pf_req_valid,
  input  logic [ADDR_W-1:0] pf_req_addr,
  output logic              pf_req_ready,
  output logic              pf_drop,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_src,
  input  logic              mem_req_ready
);
  localparam int CW = $clog2(PF_STARVE_MAX + 1);
  localparam int LW = ADDR_W - LINE_OFF;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LW-1:0]     mshr_line, pf_line, slot_line;
  logic              load_en, pf_dup, pf_force, pf_grant, win_valid;
  logic [ADDR_W-1:0] win_addr;
  req_src_e          win_src;
  assign mshr_line = mshr_req_addr[ADDR_W-1:LINE_OFF];
  assign pf_line   = pf_req_addr[ADDR_W-1:LINE_OFF];
  assign slot_line = mem_req_addr[ADDR_W-1:LINE_OFF];
  // A slot being consumed this cycle no longer shadows the prefetch line
  assign pf_dup   = (mshr_req_valid && pf_line == mshr_line) ||
                    (mem_req_valid && !mem_req_ready && pf_line == slot_line);
  assign pf_drop  = pf_req_valid && pf_dup;
  assign pf_force = starve_cnt_q == CW'(PF_STARVE_MAX);
  assign pf_grant = load_en && pf_req_valid && !pf_dup && (pf_force || !mshr_req_valid);
  assign mshr_req_ready = load_en && mshr_req_valid && !pf_grant;
  assign pf_req_ready   = pf_drop || pf_grant;
  assign win_valid = mshr_req_ready || pf_grant;
  assign win_src   = pf_grant ? SRC_PREF : SRC_DEMAND;
  assign win_addr  = {pf_grant ? pf_line : mshr_line, {LINE_OFF{1'b0}}};
  assign starve_cnt_d = (!pf_req_valid || pf_req_ready) ? '0 :
                        pf_force ? starve_cnt_q : starve_cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
  icache_req_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (win_valid),
    .in_addr_i  (win_addr),
    .in_src_i   (win_src),
    .load_en_o  (load_en),
    .out_valid_o(mem_req_valid),
    .out_addr_o (mem_req_addr),
    .out_src_o  (mem_req_src),
    .out_ready_i(mem_req_ready)
  );
endmodule

// File: tb/tb_icache_mem_arb.sv
// tb_icache_mem_arb: directed stimulus with a per-cycle handshake queue and an L2 request scoreboard
module tb_icache_mem_arb;
  logic        clk = 0, rst_n = 0;
  logic        mv = 0, pv = 0, mrdy = 0, done = 0;
  logic [31:0] ma = 0, pa = 0;
  logic        mshr_req_ready, pf_req_ready, pf_drop, mem_req_valid, mem_req_src;
  logic [31:0] mem_req_addr;
  int          checks = 0, errors = 0;
  typedef struct {logic [2:0] rd; logic [34:0] em; int cnt;} hs_t;
  typedef struct {logic [31:0] a; logic s;} mr_t;
  hs_t hs_q[$];
  mr_t mem_q[$];

  icache_mem_arb #(.ADDR_W(32), .LINE_OFF(6), .PF_STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mshr_req_valid(mv), .mshr_req_addr(ma), .mshr_req_ready(mshr_req_ready),
    .pf_req_valid(pv), .pf_req_addr(pa), .pf_req_ready(pf_req_ready), .pf_drop(pf_drop),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_src(mem_req_src),
    .mem_req_ready(mrdy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [34:0] M(input logic v, input logic s, input logic [31:0] a);
    return {1'b1, v, s, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // rd = {mshr_req_ready, pf_req_ready, pf_drop}; em = 0 skips the slot check; cnt < 0 skips counter check
  task automatic cyc(input logic m_v, input logic [31:0] m_a, input logic p_v, input logic [31:0] p_a,
                     input logic rdy, input logic [2:0] rd, input logic [34:0] em, input int cnt);
    hs_t h;
    mv = m_v; ma = m_a; pv = p_v; pa = p_a; mrdy = rdy;
    h.rd = rd; h.em = em; h.cnt = cnt;
    hs_q.push_back(h);
    @(posedge clk); #1;
  endtask

  task automatic expm(input logic [31:0] a, input logic s);
    mr_t m;
    m.a = a; m.s = s;
    mem_q.push_back(m);
  endtask

  always @(negedge clk) begin
    hs_t h;
    mr_t m;
    if (!rst_n) begin
      chk("rst_valid", 32'(mem_req_valid), 0);
      chk("rst_addr", mem_req_addr, 0);
      chk("rst_src", 32'(mem_req_src), 0);
    end
    if (hs_q.size() != 0) begin
      h = hs_q.pop_front();
      chk("mshr_ready", 32'(mshr_req_ready), 32'(h.rd[2]));
      chk("pf_ready", 32'(pf_req_ready), 32'(h.rd[1]));
      chk("pf_drop", 32'(pf_drop), 32'(h.rd[0]));
      if (h.em[34]) begin
        chk("slot_valid", 32'(mem_req_valid), 32'(h.em[33]));
        if (h.em[33]) begin
          chk("slot_src", 32'(mem_req_src), 32'(h.em[32]));
          chk("slot_addr", mem_req_addr, h.em[31:0]);
        end
      end
      if (h.cnt >= 0) chk("starve_cnt", 32'(dut.starve_cnt_q), 32'(h.cnt));
    end
    if (rst_n && mem_req_valid && mrdy) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_l2_req actual=%h required=none", mem_req_addr);
      end else begin
        m = mem_q.pop_front();
        chk("l2_addr", mem_req_addr, m.a);
        chk("l2_src", 32'(mem_req_src), 32'(m.s));
      end
    end
    if (done) begin
      chk("l2_pending", mem_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // demand only
    expm(32'h1000, 0);
    cyc(1, 32'h1000, 0, 0, 1, 3'b100, M(0, 0, 0), 0);
    cyc(0, 0, 0, 0, 1, 3'b000, M(1, 0, 32'h1000), -1);
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), -1);
    // same-cycle duplicate prefetch dropped
    expm(32'h2040, 0);
    cyc(1, 32'h2040, 1, 32'h2078, 1, 3'b111, M(0, 0, 0), -1);
    cyc(0, 0, 0, 0, 1, 3'b000, M(1, 0, 32'h2040), -1);
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), -1);
    // starvation: forced prefetch win on the 9th contending cycle
    for (int i = 0; i < 8; i++) begin
      expm(32'h5000 + 32'(i) * 32'h40, 0);
      cyc(1, 32'h5000 + 32'(i) * 32'h40, 1, 32'h3000, 1, 3'b100,
          (i == 0) ? M(0, 0, 0) : M(1, 0, 32'h5000 + 32'(i - 1) * 32'h40), i);
    end
    expm(32'h3000, 1);
    cyc(1, 32'h5200, 1, 32'h3000, 1, 3'b010, M(1, 0, 32'h51C0), 8);
    expm(32'h5200, 0);
    cyc(1, 32'h5200, 0, 0, 1, 3'b100, M(1, 1, 32'h3000), 0);
    cyc(0, 0, 0, 0, 1, 3'b000, M(1, 0, 32'h5200), -1);
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), -1);
    // backpressure with slot holding 0x4000
    expm(32'h4000, 0);
    cyc(1, 32'h4000, 0, 0, 0, 3'b100, M(0, 0, 0), -1);
    cyc(0, 0, 1, 32'h4010, 0, 3'b011, M(1, 0, 32'h4000), -1);
    cyc(1, 32'h4080, 0, 0, 0, 3'b000, M(1, 0, 32'h4000), 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h4080, 1, 32'h6000, 0, 3'b000, M(1, 0, 32'h4000), i);
    expm(32'h4080, 0);
    cyc(1, 32'h4080, 1, 32'h6000, 1, 3'b100, M(1, 0, 32'h4000), 3);
    expm(32'h6000, 1);
    cyc(0, 0, 1, 32'h6000, 1, 3'b010, M(1, 0, 32'h4080), 4);
    cyc(0, 0, 0, 0, 1, 3'b000, M(1, 1, 32'h6000), 0);
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), -1);
    // async reset while the slot is valid; the held request is lost
    cyc(1, 32'h7000, 1, 32'h8000, 0, 3'b100, M(0, 0, 0), 0);
    cyc(0, 0, 1, 32'h8000, 0, 3'b000, M(1, 0, 32'h7000), 1);
    mv = 0; pv = 0;
    #2 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), 0);
    cyc(0, 0, 0, 0, 1, 3'b000, M(0, 0, 0), 0);
    done = 1;
  end
endmodule
